// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM states, the
// radix-selection threshold and the iteration-count helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Both operand widths must reach this value before the radix-4 core is used.
    localparam int MIN_FAST_WIDTH = 8;

    // Iterations needed to consume the whole dividend.
    // Radix-2 consumes 1 bit per step; radix-4 consumes 2 bits per step.
    function automatic int calc_iters(input int a_width, input int b_width);
        if ((a_width < MIN_FAST_WIDTH) || (b_width < MIN_FAST_WIDTH)) begin
            return a_width;
        end
        return (a_width + 1) / 2;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational iteration of a restoring divider.
// The incoming partial remainder is always smaller than the divisor, so after
// shifting in STEP_BITS dividend bits it is below RADIX*divisor and fits in
// B_WIDTH+2 bits. The quotient digit is the largest k with k*divisor <= shifted.
module div_step
    import div_pkg::*;
#(
    parameter int  RADIX     = 2,
    parameter int  B_WIDTH   = 8,
    localparam int STEP_BITS = (RADIX == 4) ? 2 : 1
) (
    input  logic [B_WIDTH+1:0]   rem_in,
    input  logic [STEP_BITS-1:0] bits_in,
    input  logic [B_WIDTH-1:0]   divisor,
    output logic [B_WIDTH+1:0]   rem_out,
    output logic [STEP_BITS-1:0] digit
);

    localparam int RW = B_WIDTH + 2;

    logic [RW-1:0] shifted;
    logic [RW-1:0] d1;

    // The top STEP_BITS bits of rem_in are always zero, so the truncation is lossless.
    assign shifted = RW'({rem_in, bits_in});
    assign d1      = {2'b00, divisor};

    generate
        if (RADIX == 4) begin : g_radix4
            logic [RW-1:0] d2;
            logic [RW-1:0] d3;

            assign d2 = {1'b0, divisor, 1'b0};
            assign d3 = d2 + d1;

            // Pick the largest multiple of the divisor that still fits.
            always_comb begin
                // NOTE: every output gets a value before any branch so no latch is inferred.
                digit   = 2'd0;
                rem_out = shifted;
                if (shifted >= d3) begin
                    digit   = 2'd3;
                    rem_out = shifted - d3;
                end else if (shifted >= d2) begin
                    digit   = 2'd2;
                    rem_out = shifted - d2;
                end else if (shifted >= d1) begin
                    digit   = 2'd1;
                    rem_out = shifted - d1;
                end
            end
        end else begin : g_radix2
            // Subtract the divisor when it fits, otherwise keep the shifted value.
            always_comb begin
                digit   = 1'b0;
                rem_out = shifted;
                if (shifted >= d1) begin
                    digit   = 1'b1;
                    rem_out = shifted - d1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider with valid/ready handshakes on both sides.
// A single work register shifts dividend bits out at the top while quotient
// digits shift in at the bottom; after ITERS steps it holds the quotient.
module seq_divider
    import div_pkg::*;
#(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] dividend,
    input  logic [B_WIDTH-1:0] divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH-1:0] quotient,
    output logic [B_WIDTH-1:0] remainder,
    output logic               div_by_zero
);

    localparam int ITERS     = calc_iters(A_WIDTH, B_WIDTH);
    localparam bit FAST      = (A_WIDTH >= MIN_FAST_WIDTH) && (B_WIDTH >= MIN_FAST_WIDTH);
    localparam int STEP_BITS = FAST ? 2 : 1;
    // Odd A_WIDTH with radix-4 gains one zero MSB here.
    localparam int WORK_W    = ITERS * STEP_BITS;
    localparam int CNT_W     = $clog2(ITERS + 1);
    localparam int RW        = B_WIDTH + 2;

    state_t               state;
    logic [WORK_W-1:0]    work;
    logic [WORK_W-1:0]    work_next;
    logic [B_WIDTH-1:0]   dvs;
    logic [RW-1:0]        rem;
    logic [RW-1:0]        rem_next;
    logic [STEP_BITS-1:0] digit;
    logic [CNT_W-1:0]     cnt;
    logic                 last_iter;

    // Same instance path div.u1 in both configurations.
    generate
        if (FAST) begin : div
            div_step #(
                .RADIX   (4),
                .B_WIDTH (B_WIDTH)
            ) u1 (
                .rem_in  (rem),
                .bits_in (work[WORK_W-1 -: STEP_BITS]),
                .divisor (dvs),
                .rem_out (rem_next),
                .digit   (digit)
            );
        end else begin : div
            div_step #(
                .RADIX   (2),
                .B_WIDTH (B_WIDTH)
            ) u1 (
                .rem_in  (rem),
                .bits_in (work[WORK_W-1 -: STEP_BITS]),
                .divisor (dvs),
                .rem_out (rem_next),
                .digit   (digit)
            );
        end
    endgenerate

    assign work_next = {work[WORK_W-STEP_BITS-1:0], digit};
    assign last_iter = (cnt == CNT_W'(ITERS - 1));

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            work        <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= WORK_W'(dividend);
                        dvs      <= divisor;
                        rem      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            // Zero divisor bypasses the iterations entirely.
                            quotient    <= '1;
                            remainder   <= dividend[B_WIDTH-1:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            state       <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    work <= work_next;
                    rem  <= rem_next;
                    cnt  <= cnt + 1'b1;
                    if (last_iter) begin
                        quotient  <= work_next[A_WIDTH-1:0];
                        remainder <= rem_next[B_WIDTH-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Outputs hold until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: three instances (8/8 radix-4, 16/16 radix-4,
// 6/4 radix-2) share one stimulus bus; a selector routes the handshake.
// Expected values come from plain integer division.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] dvd = '0;
    logic [15:0] dvs = '0;
    int          sel = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic       iv8, ir8, ov8, or8, z8;
    logic [7:0] q8, r8;
    logic        iv16, ir16, ov16, or16, z16;
    logic [15:0] q16, r16;
    logic       iv6, ir6, ov6, or6, z6;
    logic [5:0] q6;
    logic [3:0] r4;

    logic        in_ready_m, out_valid_m, dbz_m;
    logic [15:0] q_m, r_m;

    always #5 clk = ~clk;

    assign iv8  = in_valid && (sel == 0);
    assign iv16 = in_valid && (sel == 1);
    assign iv6  = in_valid && (sel == 2);
    assign or8  = out_ready && (sel == 0);
    assign or16 = out_ready && (sel == 1);
    assign or6  = out_ready && (sel == 2);

    seq_divider #(.A_WIDTH(8), .B_WIDTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .dividend(dvd[7:0]), .divisor(dvs[7:0]), .out_valid(ov8), .out_ready(or8),
        .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );

    seq_divider #(.A_WIDTH(16), .B_WIDTH(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .dividend(dvd), .divisor(dvs), .out_valid(ov16), .out_ready(or16),
        .quotient(q16), .remainder(r16), .div_by_zero(z16)
    );

    seq_divider #(.A_WIDTH(6), .B_WIDTH(4)) u_d6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6),
        .dividend(dvd[5:0]), .divisor(dvs[3:0]), .out_valid(ov6), .out_ready(or6),
        .quotient(q6), .remainder(r4), .div_by_zero(z6)
    );

    always_comb begin
        in_ready_m  = ir8;
        out_valid_m = ov8;
        dbz_m       = z8;
        q_m         = {8'd0, q8};
        r_m         = {8'd0, r8};
        case (sel)
            1: begin
                in_ready_m  = ir16;
                out_valid_m = ov16;
                dbz_m       = z16;
                q_m         = q16;
                r_m         = r16;
            end
            2: begin
                in_ready_m  = ir6;
                out_valid_m = ov6;
                dbz_m       = z6;
                q_m         = {10'd0, q6};
                r_m         = {12'd0, r4};
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one division on instance s, check latency and results, optionally
    // hold the result under backpressure, then consume it.
    task automatic run_op(input int s, input int a_in, input int b_in,
                          input int hold, input bit junk);
        int aw, bw, iters, a, b;
        int exp_q, exp_r, exp_z, exp_lat, lat;
        bit seen;
        logic [15:0] q_hold, r_hold;

        aw = (s == 0) ? 8 : (s == 1) ? 16 : 6;
        bw = (s == 0) ? 8 : (s == 1) ? 16 : 4;
        a  = a_in & ((1 << aw) - 1);
        b  = b_in & ((1 << bw) - 1);
        iters = ((aw < 8) || (bw < 8)) ? aw : (aw + 1) / 2;
        if (b == 0) begin
            exp_q   = (1 << aw) - 1;
            exp_r   = a % (1 << bw);
            exp_z   = 1;
            exp_lat = 1;
        end else begin
            exp_q   = a / b;
            exp_r   = a % b;
            exp_z   = 0;
            exp_lat = iters + 1;
        end

        @(negedge clk);
        sel      = s;
        dvd      = 16'(a);
        dvs      = 16'(b);
        in_valid = 1'b1;
        #1;
        check("in_ready_idle", in_ready_m, 1);
        @(posedge clk);
        #1;
        if (junk) begin
            // Keep in_valid high with different operands: must be ignored.
            dvd = 16'($urandom);
            dvs = 16'($urandom);
        end else begin
            in_valid = 1'b0;
        end

        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid_m) seen = 1'b1;
        end
        in_valid = 1'b0;
        check("latency", seen ? lat : -1, exp_lat);
        check("quotient", q_m, exp_q);
        check("remainder", r_m, exp_r);
        check("div_by_zero", dbz_m, exp_z);

        q_hold = q_m;
        r_hold = r_m;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid_m, 1);
            check("hold_in_ready", in_ready_m, 0);
            check("hold_quotient", q_m, q_hold);
            check("hold_remainder", r_m, r_hold);
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after", in_ready_m, 1);
        check("valid_after", out_valid_m, 0);
    endtask

    initial begin
        bit stray;

        #22 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready8", ir8, 1);
        check("rst_in_ready16", ir16, 1);
        check("rst_in_ready6", ir6, 1);
        check("rst_out_valid", ov8, 0);
        check("rst_quotient", q8, 0);
        check("rst_remainder", r8, 0);
        check("rst_dbz", z8, 0);

        // Directed cases
        run_op(0, 100, 7, 0, 0);
        run_op(0, 5, 0, 0, 0);
        run_op(1, 50000, 123, 0, 0);
        run_op(2, 63, 15, 0, 0);
        run_op(2, 1, 2, 0, 0);
        run_op(1, 40000, 0, 0, 0);
        run_op(2, 45, 0, 0, 0);

        // Backpressure, then back-to-back full-scale operands
        run_op(0, 255, 1, 10, 0);
        run_op(0, 255, 255, 0, 0);

        // Operands held valid during BUSY are ignored
        run_op(0, 200, 9, 0, 1);
        run_op(1, 65535, 3, 0, 1);

        // Reset during BUSY discards the in-flight result
        @(negedge clk);
        sel      = 0;
        dvd      = 16'd100;
        dvs      = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", ov8, 0);
        check("rst_mid_in_ready", ir8, 1);
        check("rst_mid_quotient", q8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov8) stray = 1'b1;
        end
        check("no_stray_valid", stray, 0);
        check("in_ready_post_rst", ir8, 1);
        run_op(0, 9, 3, 0, 0);

        // Randomised operands on every configuration
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 15; k++) begin
                int a, b;
                a = int'($urandom);
                case ($urandom_range(0, 4))
                    0:       b = 0;
                    1:       b = int'($urandom_range(1, 5));
                    default: b = int'($urandom);
                endcase
                run_op(s, a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
